// File: rtl/intctl_n.sv
// Z80 IM2 interrupt controller: latches strobe sources into pending requests,
// arbitrates (fixed or round-robin), drives int_n and the acknowledged vector index.
module intctl_n #(
    parameter int NSRC    = 3,
    parameter int INT_LEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m1_n,
    input  logic            iorq_n,
    input  logic [NSRC-1:0] int_stbs,
    input  logic [7:0]      din,
    input  logic            ena_wr,
    input  logic            req_wr,
    input  logic            mode_wr,
    output logic [7:0]      req_rd,
    output logic [7:0]      lost_rd,
    output logic            int_n,
    output logic [2:0]      int_vector
);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] ena_q, ena_d;
    logic [NSRC-1:0] req_q, req_d;
    logic [NSRC-1:0] lost_q, lost_d;
    logic            mode_q, mode_d;
    logic            ack_q, ack_d;
    logic            int_n_q, int_n_d;
    logic [2:0]      vec_q, vec_d;
    logic [2:0]      rr_last_q, rr_last_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [NSRC-1:0] active;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] sw_set;
    logic [NSRC-1:0] sw_clr;
    logic [NSRC-1:0] ack_clr;
    logic [2:0]      winner;
    logic            found;
    int              idx;

    assign active = req_q & ena_q;
    assign mask   = din[NSRC-1:0];

    // Round-robin search starts just above the last serviced source and wraps.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NSRC; i++) begin
            idx = mode_q ? ((int'(rr_last_q) + 1 + i) % NSRC) : i;
            if (!found && active[idx]) begin
                winner = 3'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        int_n_d   = int_n_q;
        vec_d     = vec_q;
        rr_last_d = rr_last_q;
        ack_clr   = '0;
        case (state_q)
            S_IDLE: begin
                int_n_d = 1'b1;
                vec_d   = winner;
                if (|active) begin
                    state_d = S_ASSERT;
                    cnt_d   = 8'(INT_LEN - 1);
                    int_n_d = 1'b0;
                end
            end
            S_ASSERT: begin
                if (ack_q) begin
                    // Clear by the frozen vector so a priority change cannot misroute it.
                    for (int k = 0; k < NSRC; k++) ack_clr[k] = (vec_q == 3'(k));
                    rr_last_d = vec_q;
                    int_n_d   = 1'b1;
                    state_d   = S_HOLD;
                end else begin
                    vec_d = winner;
                    if (!(|active) || cnt_q == 8'd0) begin
                        state_d = S_IDLE;
                        int_n_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        int_n_d = 1'b0;
                    end
                end
            end
            S_HOLD: begin
                int_n_d = 1'b1;
                if (!ack_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                int_n_d = 1'b1;
            end
        endcase
    end

    // A strobe wins over a same-cycle clear and does not count as lost then.
    always_comb begin
        sw_set = (req_wr && din[7])  ? mask : '0;
        sw_clr = (req_wr && !din[7]) ? mask : '0;
        req_d  = (req_q & ~(sw_clr | ack_clr)) | sw_set | int_stbs;
        lost_d = (lost_q & ~sw_clr) | (int_stbs & req_q & ~(sw_clr | ack_clr));
        ena_d  = ena_q;
        if (ena_wr) ena_d = din[7] ? (ena_q | mask) : (ena_q & ~mask);
        mode_d = mode_wr ? din[0] : mode_q;
        ack_d  = !m1_n && !iorq_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ena_q     <= '0;
            req_q     <= '0;
            lost_q    <= '0;
            mode_q    <= 1'b0;
            ack_q     <= 1'b0;
            int_n_q   <= 1'b1;
            vec_q     <= '0;
            rr_last_q <= 3'(NSRC - 1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ena_q     <= ena_d;
            req_q     <= req_d;
            lost_q    <= lost_d;
            mode_q    <= mode_d;
            ack_q     <= ack_d;
            int_n_q   <= int_n_d;
            vec_q     <= vec_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign req_rd     = 8'(req_q);
    assign lost_rd    = 8'(lost_q);
    assign int_n      = int_n_q;
    assign int_vector = vec_q;

endmodule

// File: tb/tb_intctl_n.sv
// Directed bench for intctl_n: expected vectors queued at stimulus time,
// compared when the acknowledge cycle freezes int_vector.
module tb_intctl_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m1_n;
    logic       iorq_n;
    logic [2:0] int_stbs;
    logic [7:0] din;
    logic       ena_wr;
    logic       req_wr;
    logic       mode_wr;
    logic [7:0] req_rd;
    logic [7:0] lost_rd;
    logic       int_n;
    logic [2:0] int_vector;

    int         total = 0;
    int         bad   = 0;
    logic [2:0] sb[$];

    intctl_n #(.NSRC(3), .INT_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .m1_n(m1_n), .iorq_n(iorq_n),
        .int_stbs(int_stbs), .din(din), .ena_wr(ena_wr), .req_wr(req_wr),
        .mode_wr(mode_wr), .req_rd(req_rd), .lost_rd(lost_rd),
        .int_n(int_n), .int_vector(int_vector)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_ena(input logic [7:0] v);
        din = v; ena_wr = 1'b1; tick(); ena_wr = 1'b0; din = 8'h00;
    endtask

    task automatic wr_req(input logic [7:0] v);
        din = v; req_wr = 1'b1; tick(); req_wr = 1'b0; din = 8'h00;
    endtask

    task automatic wr_mode(input logic [7:0] v);
        din = v; mode_wr = 1'b1; tick(); mode_wr = 1'b0; din = 8'h00;
    endtask

    task automatic strobe(input logic [2:0] s);
        int_stbs = s; tick(); int_stbs = 3'b000;
    endtask

    task automatic wait_low();
        int n = 0;
        while (int_n !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk("int_n_asserted", 8'(int_n), 8'h00);
    endtask

    task automatic pop_vec(input string tag);
        logic [2:0] v;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=queue_empty expected=entry", tag);
        end else begin
            v = sb.pop_front();
            chk(tag, 8'(int_vector), 8'(v));
        end
    endtask

    // Three-cycle M1+IORQ acknowledge, then let HOLD drain back to IDLE.
    task automatic service(input logic [7:0] exp_req);
        wait_low();
        m1_n = 1'b0; iorq_n = 1'b0;
        tick(); tick(); tick();
        m1_n = 1'b1; iorq_n = 1'b1;
        pop_vec("ack_vector");
        chk("req_after_ack", req_rd, exp_req);
        chk("int_n_in_hold", 8'(int_n), 8'h01);
        tick(); tick();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; m1_n = 1'b1; iorq_n = 1'b1; int_stbs = 3'b000;
        din = 8'h00; ena_wr = 1'b0; req_wr = 1'b0; mode_wr = 1'b0;
        #12;
        chk("rst_int_n", 8'(int_n), 8'h01);
        chk("rst_req", req_rd, 8'h00);
        chk("rst_lost", lost_rd, 8'h00);
        chk("rst_vector", 8'(int_vector), 8'h00);
        rst_n = 1'b1;
        tick();

        // single source, basic acknowledge
        wr_ena(8'h81);
        strobe(3'b001);
        chk("t1_req_latched", req_rd, 8'h01);
        chk("t1_int_n_still_high", 8'(int_n), 8'h01);
        tick();
        chk("t1_int_n_low", 8'(int_n), 8'h00);
        sb.push_back(3'd0);
        service(8'h00);
        tick();
        chk("t1_idle_high", 8'(int_n), 8'h01);

        // fixed priority
        wr_ena(8'h87);
        strobe(3'b110);
        sb.push_back(3'd1);
        sb.push_back(3'd2);
        service(8'h04);
        service(8'h00);

        // round robin: make rr_last = 1, then 0 must beat 1
        wr_mode(8'h01);
        strobe(3'b010);
        sb.push_back(3'd1);
        service(8'h00);
        strobe(3'b011);
        sb.push_back(3'd0);
        sb.push_back(3'd1);
        service(8'h02);
        service(8'h00);

        // timeout
        wr_mode(8'h00);
        strobe(3'b001);
        tick();
        n = 0;
        while (int_n === 1'b0 && n < 100) begin
            n++;
            tick();
        end
        chk("t3_low_cycles", 8'(n), 8'd32);
        chk("t3_high_gap", 8'(int_n), 8'h01);
        tick();
        chk("t3_reassert", 8'(int_n), 8'h00);
        chk("t3_req_kept", req_rd, 8'h01);
        wr_req(8'h01);
        tick();
        chk("t3_drop_int_n", 8'(int_n), 8'h01);
        chk("t3_req_cleared", req_rd, 8'h00);

        // lost events on a disabled source, software set/clear
        wr_ena(8'h07);
        strobe(3'b010);
        strobe(3'b010);
        chk("t4_lost", lost_rd, 8'h02);
        chk("t4_req", req_rd, 8'h02);
        chk("t4_int_n_disabled", 8'(int_n), 8'h01);
        wr_req(8'h84);
        chk("t4_sw_set", req_rd, 8'h06);
        wr_req(8'h06);
        chk("t4_req_clr", req_rd, 8'h00);
        chk("t4_lost_clr", lost_rd, 8'h00);

        // strobe collides with the acknowledge clear
        wr_ena(8'h81);
        strobe(3'b001);
        sb.push_back(3'd0);
        wait_low();
        m1_n = 1'b0; iorq_n = 1'b0;
        tick();
        int_stbs = 3'b001;
        tick();
        int_stbs = 3'b000;
        chk("t5_req_kept", req_rd, 8'h01);
        chk("t5_no_lost", lost_rd, 8'h00);
        chk("t5_int_n_hold", 8'(int_n), 8'h01);
        tick();
        m1_n = 1'b1; iorq_n = 1'b1;
        pop_vec("t5_vector");
        tick(); tick();
        sb.push_back(3'd0);
        service(8'h00);
        chk("t5_lost_final", lost_rd, 8'h00);

        // asynchronous reset during ASSERT
        wr_ena(8'h87);
        strobe(3'b101);
        wait_low();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_int_n", 8'(int_n), 8'h01);
        chk("t6_req", req_rd, 8'h00);
        chk("t6_lost", lost_rd, 8'h00);
        #10;
        rst_n = 1'b1;
        tick();
        chk("t6_after_release", 8'(int_n), 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intctl_n.md
Name: intctl_n

Overview:
Parametrised Z80 IM2 interrupt controller for the NeoGS core. It latches up to 7 strobe sources into pending requests and applies per-source enables. It drives int_n with a bounded-length assertion and supplies the vector index for the data-bus mux during the M1+IORQ acknowledge cycle. It adds two things: fixed or round-robin priority, and per-source lost-event flags.

Parameters:
NSRC, 3, number of interrupt sources, legal range 1..7.
INT_LEN, 32, maximum clk cycles int_n stays low without an acknowledge, legal range 2..255.

Ports:
clk  input  1  Z80 clock (clk_fpga domain).
rst_n  input  1  asynchronous active-low reset.
m1_n  input  1  Z80 M1, synchronous to clk.
iorq_n  input  1  Z80 IORQ, synchronous to clk.
int_stbs  input  NSRC  one-cycle event strobes, bit k = source k.
din  input  8  write data from the ports block.
ena_wr  input  1  one-cycle strobe: update enables.
req_wr  input  1  one-cycle strobe: update requests and lost flags.
mode_wr  input  1  one-cycle strobe: din[0] = 1 selects round-robin, 0 selects fixed priority.
req_rd  output  8  {zero padding, req[NSRC-1:0]}.
lost_rd  output  8  {zero padding, lost[NSRC-1:0]}.
int_n  output  1  active-low interrupt request to the Z80.
int_vector  output  3  index of the source being serviced; the top-level places it into vector byte {2'b11, int_vector, 3'b111}.

Behaviour:
- Reset (asynchronous): ena, req and lost all 0; mode = fixed; int_n = 1; int_vector = 0; state = IDLE; rr_last = NSRC-1; timeout counter = 0.
- ena_wr:
  - din[7] = 1: ena |= din[NSRC-1:0].
  - din[7] = 0: ena &= ~din[NSRC-1:0].
- req_wr:
  - din[7] = 1: req |= mask (software-triggered interrupt).
  - din[7] = 0: req &= ~mask and lost &= ~mask.
- Strobes: int_stbs[k] sets req[k]. If req[k] is already 1 in that cycle, lost[k] is also set. Strobes on disabled sources still latch into req.
- Set priority:
  - A strobe in the same cycle as a software clear or an acknowledge clear of the same bit leaves req = 1.
  - lost is not set in that case.
- active = req & ena.
- Winner selection:
  - Fixed mode: lowest set index of active.
  - Round-robin mode: first set index of active searching upward from rr_last+1, wrapping modulo NSRC.
- ack = registered (!m1_n && !iorq_n), one flop.
- State machine:
  - IDLE: int_n = 1; int_vector <= winner each cycle. If active != 0, go to ASSERT, load counter = INT_LEN-1, and drive int_n = 0 from the next cycle.
  - ASSERT: int_n = 0; int_vector <= winner each cycle.
    - ack = 1: freeze int_vector; clear req[int_vector]; rr_last <= int_vector; int_n = 1; go to HOLD.
    - Otherwise, if active becomes 0 (disabled or cleared): go to IDLE, int_n = 1 next cycle.
    - Otherwise, if counter = 0: go to IDLE (timeout, req untouched).
    - Otherwise decrement counter.
  - HOLD: int_n = 1; int_vector frozen. When ack = 0, go to IDLE.
- Minimum int_n high time between assertions: 1 cycle.
- The acknowledge clear uses the frozen vector. Priority changes after ack cannot misroute the clear.
- mode_wr takes effect on the next winner evaluation. It does not alter an in-progress HOLD.
- An ack seen in IDLE (spurious) is ignored; no state change.
- All outputs are registered except req_rd and lost_rd, which are direct register views.

Test Plan:
1. Reset, ena_wr din=8'h81, one pulse on int_stbs[0] -> req_rd=8'h01; int_n low 2 cycles after the strobe; M1+IORQ low for 3 cycles -> int_vector=0 frozen, req_rd=8'h00, int_n high; FSM returns to IDLE after the ack ends.
2. Fixed mode, ena=3'b111, sources 2 and 1 strobed together -> first ack services 1, second services 2. Repeat in round-robin mode with rr_last=1 and sources 0 and 1 pending -> services 0 first? No: services 1 is not eligible first; the search starts at 2, wraps to 0, so 0 is serviced before 1.
3. Source 0 pending, no ack, INT_LEN=32 -> int_n low exactly 32 cycles, high 1 cycle, low again; req_rd stays 8'h01.
4. Second strobe on source 1 before service -> lost_rd=8'h02. req_wr din=8'h02 -> req_rd and lost_rd bit 1 cleared.
5. Strobe on source 0 in the exact cycle its ack clears it -> req_rd bit 0 stays 1, lost_rd bit 0 = 0, int_n re-asserts after HOLD.
6. rst_n asserted during ASSERT with req=3'b101 -> int_n=1, req_rd=lost_rd=8'h00 immediately, without waiting for clk.
